// File: rtl/ka_mul_seq.sv
// Sequential one-level Karatsuba carry-less multiplier over GF(2)[x].
// One half-width schoolbook multiplier is time-shared across P0, P1 and P2.
module ka_mul_seq #(
  parameter int unsigned N      = 58,
  parameter bit          REDUCE = 1'b0,
  parameter logic [N-1:0] POLY  = N'(58'h80001)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-2:0]  o
);

  localparam int unsigned L  = N / 2;
  localparam int unsigned U  = N - L;
  localparam int unsigned PW = 2 * U - 1;
  localparam int unsigned OW = 2 * N - 1;

  typedef enum logic [2:0] {StIdle, StLo, StHi, StMid, StRed, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   p0_q, p0_d, p1_q, p1_d;
  logic [OW-1:0]   o_q, o_d;
  logic            out_valid_q, out_valid_d;

  logic [U-1:0]    al, au, bl, bu;
  logic [U-1:0]    sx, sy;
  logic [PW-1:0]   sp, mid;
  logic [OW-1:0]   comb_o;

  function automatic logic [PW-1:0] clmul(input logic [U-1:0] x, input logic [U-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(U); i++) begin
      if (y[i]) r = r ^ (PW'(x) << i);
    end
    return r;
  endfunction

  // Fold each high coefficient down via x^N == POLY, top bit first.
  function automatic logic [OW-1:0] reduce(input logic [OW-1:0] p);
    logic [OW-1:0] r;
    r = p;
    for (int i = int'(OW) - 1; i >= int'(N); i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        r    = r ^ (OW'(POLY) << (i - int'(N)));
      end
    end
    return r;
  endfunction

  assign al = U'(a_q[L-1:0]);
  assign au = a_q[N-1:L];
  assign bl = U'(b_q[L-1:0]);
  assign bu = b_q[N-1:L];

  always_comb begin
    sx = '0;
    sy = '0;
    unique case (state_q)
      StLo:    begin sx = al;      sy = bl;      end
      StHi:    begin sx = au;      sy = bu;      end
      StMid:   begin sx = au ^ al; sy = bu ^ bl; end
      default: begin sx = '0;      sy = '0;      end
    endcase
  end

  assign sp     = clmul(sx, sy);
  assign mid    = p0_q ^ p1_q ^ sp;
  assign comb_o = (OW'(p1_q) << (2 * L)) ^ (OW'(mid) << L) ^ OW'(p0_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    o_d         = o_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = StLo;
        end
      end
      StLo: begin
        p0_d    = sp;
        state_d = StHi;
      end
      StHi: begin
        p1_d    = sp;
        state_d = StMid;
      end
      StMid: begin
        o_d = comb_o;
        if (REDUCE) begin
          state_d = StRed;
        end else begin
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StRed: begin
        o_d         = reduce(o_q);
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign o         = o_q;

endmodule

// File: tb/tb_ka_mul_seq.sv
// Directed and random checks of ka_mul_seq: full product (N=58), reduced (N=58), odd width (N=7).
module tb_ka_mul_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic         out_ready;
  logic [57:0]  a, b;
  logic [2:0]   in_ready, out_valid;
  logic [114:0] o0, o1;
  logic [12:0]  o2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ka_mul_seq #(.N(58), .REDUCE(1'b0), .POLY(58'h80001)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready), .o(o0)
  );

  ka_mul_seq #(.N(58), .REDUCE(1'b1), .POLY(58'h80001)) u_red (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready), .o(o1)
  );

  ka_mul_seq #(.N(7), .REDUCE(1'b0), .POLY(7'h03)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[6:0]), .b(b[6:0]), .out_valid(out_valid[2]), .out_ready(out_ready), .o(o2)
  );

  typedef struct {
    int           d;
    logic [57:0]  a;
    logic [57:0]  b;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  function automatic logic [127:0] clmul_ref(input logic [63:0] x, input logic [63:0] y,
                                             input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (y[i]) r = r ^ ({64'b0, x} << i);
    end
    return r;
  endfunction

  function automatic logic [127:0] red_ref(input logic [127:0] p, input int n,
                                           input logic [63:0] poly);
    logic [127:0] r;
    r = p;
    for (int i = 2 * n - 2; i >= n; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        r    = r ^ ({64'b0, poly} << (i - n));
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] get_o(input int d);
    case (d)
      0:       return {13'b0, o0};
      1:       return {13'b0, o1};
      default: return {115'b0, o2};
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one step after a rising edge with the selected DUT idle and out_ready=1.
  task automatic transact(input int d, input logic [57:0] xa, input logic [57:0] xb,
                          output logic [127:0] res, output int lat);
    int busy_hi;
    busy_hi     = 0;
    a           = xa;
    b           = xb;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 20) begin
      if (in_ready[d]) busy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready[d]) busy_hi++;
    res = get_o(d);
    check($sformatf("busy_in_ready d%0d", d), busy_hi, 0);
    @(posedge clk); #1;
    check($sformatf("consume_handshake d%0d", d), {out_valid[d], in_ready[d]}, 2'b01);
  endtask

  initial begin
    vec_t         vecs[$];
    logic [127:0] res, held;
    logic [63:0]  ra, rb;
    int           lat, stuck, ghost;

    vecs.push_back('{0, 58'd1, 58'd1, 128'd1, 3});
    vecs.push_back('{0, 58'd3, 58'd3, 128'd5, 3});
    vecs.push_back('{0, 58'h3FF_FFFF_FFFF_FFFF, 58'd1, 128'h3FF_FFFF_FFFF_FFFF, 3});
    vecs.push_back('{0, 58'd1 << 57, 58'd1 << 57, 128'd1 << 114, 3});
    vecs.push_back('{0, 58'h3000_0000, 58'h3000_0000, (128'd1 << 58) | (128'd1 << 56), 3});
    vecs.push_back('{1, 58'd1 << 57, 58'd2, 128'h80001, 4});
    vecs.push_back('{1, 58'd1, 58'd5, 128'd5, 4});
    vecs.push_back('{2, 58'h7F, 58'h7F, 128'h1555, 3});
    vecs.push_back('{2, 58'h5, 58'h3, 128'hF, 3});

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 3'b111);
    check("reset_out_valid", out_valid, 3'b000);
    check("reset_o_full", o0, 0);
    check("reset_o_red", o1, 0);
    check("reset_o_odd", o2, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      transact(vecs[i].d, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_o", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: result must hold while new operands are offered and ignored.
    out_ready   = 1'b0;
    a           = 58'd6;
    b           = 58'd3;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 3);
    held  = get_o(0);
    check("bp_o", held, 128'd10);
    stuck = 0;
    for (int i = 0; i < 5; i++) begin
      a           = {$urandom(), $urandom()};
      b           = {$urandom(), $urandom()};
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      if (get_o(0) !== held || !out_valid[0] || in_ready[0]) stuck++;
    end
    check("bp_hold", stuck, 0);
    in_valid[0] = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {out_valid[0], in_ready[0]}, 2'b01);
    ghost = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid[0]) ghost++;
    end
    check("bp_no_phantom", ghost, 0);

    for (int i = 0; i < 200; i++) begin
      ra = {$urandom(), $urandom()} & 64'h03FF_FFFF_FFFF_FFFF;
      rb = {$urandom(), $urandom()} & 64'h03FF_FFFF_FFFF_FFFF;
      transact(0, ra[57:0], rb[57:0], res, lat);
      check($sformatf("rand_full%0d", i), res, clmul_ref(ra, rb, 58));
    end
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom(), $urandom()} & 64'h03FF_FFFF_FFFF_FFFF;
      rb = {$urandom(), $urandom()} & 64'h03FF_FFFF_FFFF_FFFF;
      transact(1, ra[57:0], rb[57:0], res, lat);
      check($sformatf("rand_red%0d", i), res, red_ref(clmul_ref(ra, rb, 58), 58, 64'h80001));
    end
    for (int i = 0; i < 50; i++) begin
      ra = 64'($urandom_range(127));
      rb = 64'($urandom_range(127));
      transact(2, ra[57:0], rb[57:0], res, lat);
      check($sformatf("rand_odd%0d", i), res, clmul_ref(ra, rb, 7));
    end

    // Reset while the full-product DUT is in HI: operation must vanish.
    a           = 58'd9;
    b           = 58'd5;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid[0], 1'b0);
    check("rst_mid_o", o0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ghost = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid[0]) ghost++;
    end
    check("rst_no_output", ghost, 0);
    check("rst_o_zero", o0, 0);
    check("rst_in_ready", in_ready[0], 1'b1);
    transact(0, 58'd6, 58'd3, res, lat);
    check("rst_fresh_o", res, 128'd10);
    check("rst_fresh_latency", lat, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
